btb_2bc: RTL

- Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating counters. Successor to the single-strong-bit BTB.
- Sits beside the IF-stage PC mux: a combinational lookup on the fetch PC yields hit and predicted target in the same cycle. The EX stage returns the branch outcome one update per cycle.
- Adds a hardware init/flush walker that invalidates RAM without a memory reset, plus saturating statistics counters.

---
 rtl/btb_pkg.sv | 26 ++
 rtl/btb_2bc_if.sv | 32 +++
 rtl/btb_ram.sv | 29 ++
 rtl/btb_2bc.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-bit-counter branch target buffer.
package btb_pkg;

   // Per-entry 2-bit saturating direction counter; bit 1 is the taken prediction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Controller state: INIT walks the RAM writing zero entries, RUN predicts/updates.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/btb_2bc_if.sv
// Fetch-side lookup and EX-side update bus of the branch target buffer.
interface btb_2bc_if #(
   parameter int PC_W = 16
) ();
   // lookup (IF stage)
   logic            en;
   logic [PC_W-1:0] lk_pc;
   logic            lk_stall;
   logic            pred_hit;
   logic [PC_W-1:0] pred_target;
   // resolved branch (EX stage)
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic [PC_W-1:0] upd_target;
   logic            upd_pred_hit;
   logic [PC_W-1:0] upd_pred_target;

   // pipeline side drives PCs and outcomes, receives the prediction
   modport master (
      output en, lk_pc, lk_stall,
      output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_hit, upd_pred_target,
      input  pred_hit, pred_target
   );

   // BTB side
   modport slave (
      input  en, lk_pc, lk_stall,
      input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_hit, upd_pred_target,
      output pred_hit, pred_target
   );
endinterface

// File: rtl/btb_ram.sv
// Entry storage: one synchronous write port, two asynchronous read ports
// (fetch lookup and update read-modify-write).
module btb_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write commits at the clock edge, so same-cycle reads see the old entry.
   // NOTE: the array has no reset; the controller's INIT walk clears it instead,
   // which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/btb_2bc.sv
// Direct-mapped branch target buffer with 2-bit saturating counters,
// hardware init/flush walker and saturating statistics counters.
module btb_2bc
   import btb_pkg::*;
#(
   parameter int   PC_W      = 16,
   parameter int   IDX_W     = 9,
   parameter int   CNT_W     = 16,
   parameter ctr_t ALLOC_CTR = WT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             stat_clr,
   btb_2bc_if.slave         bus,
   output logic             busy,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] mispr_cnt
);

   localparam int TAG_W   = PC_W - IDX_W;
   localparam int ENTRY_W = TAG_W + 1 + 2 + PC_W;

   // Entry layout depends on the top-level widths, so it is declared here.
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             valid;
      ctr_t             ctr;
      logic [PC_W-1:0]  target;
   } btb_entry_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] walk_idx, walk_idx_nxt;

   btb_entry_t       lk_e, up_e, wr_e;
   logic             we;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_match;
   logic             pred_hit_i;
   logic             mispredict;

   assign lk_idx = bus.lk_pc[IDX_W-1:0];
   assign lk_tag = bus.lk_pc[PC_W-1:IDX_W];
   assign up_idx = bus.upd_pc[IDX_W-1:0];
   assign up_tag = bus.upd_pc[PC_W-1:IDX_W];

   btb_ram #(
      .ADDR_W (IDX_W),
      .DATA_W (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (wr_idx),
      .wdata   (wr_e),
      .raddr_a (lk_idx),
      .rdata_a (lk_e),
      .raddr_b (up_idx),
      .rdata_b (up_e)
   );

   // State register and walk index; reset always restarts the walk.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         walk_idx <= '0;
      end else begin
         state    <= state_nxt;
         walk_idx <= walk_idx_nxt;
      end
   end

   // Next state: walk DEPTH entries in INIT, flush restarts the walk from 0.
   always_comb begin
      state_nxt    = state;
      walk_idx_nxt = walk_idx;
      case (state)
         INIT: begin
            if (flush) begin
               walk_idx_nxt = '0;
            end else begin
               walk_idx_nxt = walk_idx + IDX_W'(1);
               if (walk_idx == '1) state_nxt = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt    = INIT;
               walk_idx_nxt = '0;
            end
         end
         default: begin
            state_nxt    = INIT;
            walk_idx_nxt = '0;
         end
      endcase
   end

   assign up_match = up_e.valid && (up_e.tag == up_tag);

   // Outputs: busy flag, and the RAM write port (walk clear or branch update).
   // NOTE: every signal gets a default before the branches so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      busy   = (state == INIT);
      we     = 1'b0;
      wr_idx = up_idx;
      wr_e   = '0;
      if (state == INIT) begin
         we     = 1'b1;
         wr_idx = walk_idx;
      end else if (bus.upd_valid && !flush) begin
         if (up_match) begin
            if (bus.upd_taken) begin
               we          = 1'b1;
               wr_e        = up_e;
               wr_e.ctr    = sat_inc(up_e.ctr);
               wr_e.target = bus.upd_target;
            end else if (up_e.ctr == WNT) begin
               // weakest state losing again: drop the entry
               we = 1'b1;
            end else if (up_e.ctr != SNT) begin
               we       = 1'b1;
               wr_e     = up_e;
               wr_e.ctr = sat_dec(up_e.ctr);
            end
         end else if (bus.upd_taken) begin
            // allocate, evicting whatever alias held this index
            we          = 1'b1;
            wr_e.tag    = up_tag;
            wr_e.valid  = 1'b1;
            wr_e.ctr    = ALLOC_CTR;
            wr_e.target = bus.upd_target;
         end
      end
   end

   assign pred_hit_i = (state == RUN) && bus.en && !bus.lk_stall && lk_e.valid &&
                       (lk_e.tag == lk_tag) && (lk_e.ctr inside {WT, ST});
   assign bus.pred_hit    = pred_hit_i;
   assign bus.pred_target = lk_e.target;

   assign mispredict = bus.upd_valid &&
                       ((bus.upd_pred_hit != bus.upd_taken) ||
                        (bus.upd_pred_hit && bus.upd_taken &&
                         (bus.upd_pred_target != bus.upd_target)));

   // Saturating statistics; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt    <= '0;
         hit_cnt   <= '0;
         mispr_cnt <= '0;
      end else if (stat_clr) begin
         br_cnt    <= '0;
         hit_cnt   <= '0;
         mispr_cnt <= '0;
      end else begin
         if (bus.upd_valid && !(&br_cnt))  br_cnt    <= br_cnt + CNT_W'(1);
         if (pred_hit_i && !(&hit_cnt))    hit_cnt   <= hit_cnt + CNT_W'(1);
         if (mispredict && !(&mispr_cnt))  mispr_cnt <= mispr_cnt + CNT_W'(1);
      end
   end

endmodule
